// File: rtl/miner_pkg.sv
// miner_pkg
// Shared definitions for the miner datapath.
//   - send_state_t        : encoding of the golden-nonce send state machine
//   - GOLDEN_NONCE_OFFSET : distance between the nonce register value at the
//                           moment a hit is flagged and the nonce that actually
//                           produced it. This is a function of the hasher unroll
//                           setting, and the control unit uses the same function.
package miner_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    DRAIN = 2'd2
  } send_state_t;

  // The pipeline is 2^(7 - loop_log2) stages deep, plus one cycle for the
  // golden-ticket register itself.
  function automatic logic [31:0] GOLDEN_NONCE_OFFSET(input int unsigned loop_log2);
    return (32'd1 << (7 - loop_log2)) + 32'd1;
  endfunction

endpackage

// File: rtl/nonce_fifo_2w1r.sv
// nonce_fifo_2w1r
// Circular buffer of 32-bit words. It has two write ports and one read port.
//
// Ports:
//   clk, reset          : clock, asynchronous active-high reset
//   wr0_en / wr0_data   : write port 0. It takes priority when space is short.
//   wr1_en / wr1_data   : write port 1. Its word lands after port 0's word
//                         when both ports are accepted.
//   rd_en               : pops the head entry. It is ignored when empty.
//   rd_data             : head entry, read combinationally.
//   count               : occupancy, registered
//   wr0_accept          : port 0's write is stored this cycle
//   wr1_accept          : port 1's write is stored this cycle
//
// Space is judged from the occupancy at the start of the cycle. A pop in the
// same cycle does not make room for that cycle's writes.
module nonce_fifo_2w1r #(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr0_en,
  input  logic [31:0]           wr0_data,
  input  logic                  wr1_en,
  input  logic [31:0]           wr1_data,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  wr0_accept,
  output logic                  wr1_accept
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] TWO        = (DEPTH_LOG2+1)'(2);

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr1_addr;
  logic [DEPTH_LOG2:0]   free_slots;
  logic [1:0]            n_wr;
  logic                  pop;

  assign free_slots = FULL_COUNT - count;
  assign wr0_accept = wr0_en && (free_slots != '0);
  // Port 1 needs a second free slot only when port 0 has already used one.
  assign wr1_accept = wr1_en && (wr0_accept ? (free_slots >= TWO) : (free_slots != '0));
  assign wr1_addr   = wr_ptr + DEPTH_LOG2'(wr0_accept);
  assign n_wr       = {1'b0, wr0_accept} + {1'b0, wr1_accept};
  assign pop        = rd_en && (count != '0);
  assign rd_data    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + DEPTH_LOG2'(n_wr);
      rd_ptr <= rd_ptr + DEPTH_LOG2'(pop);
      count  <= count + (DEPTH_LOG2+1)'(n_wr) - (DEPTH_LOG2+1)'(pop);
    end
  end

  // Storage is not reset. Stale contents are never read because count gates
  // every read.
  always_ff @(posedge clk) begin
    if (wr0_accept) mem[wr_ptr]   <= wr0_data;
    if (wr1_accept) mem[wr1_addr] <= wr1_data;
  end

endmodule

// File: rtl/golden_nonce_queue.sv
// golden_nonce_queue
// Collects golden-nonce hits from the two hasher lanes and removes the
// pipeline offset from each one. It queues the corrected nonces and hands them
// to serial_transmit one word at a time.
//
// Ports:
//   clk          : hash clock
//   reset        : asynchronous, active-high
//   hit0, nonce0 : lane-0 golden ticket and the current nonce register
//   hit1, nonce1 : lane-1 golden ticket and the current nonce register
//   busy         : transmitter busy flag
//   send         : one-cycle transmit request
//   word         : corrected nonce. It is valid with send and held until the
//                  next send.
//   count        : queue occupancy
//   drop_count   : saturating count of hits lost to a full queue
//   dbg_state    : current send state (send_state_t encoding)
//
// Handshake with serial_transmit: send is a single-cycle request, and word is
// stable from that cycle onward. The transmitter accepts by raising busy and
// finishes by lowering it. A new request is made only from IDLE with busy low.
// If busy never rises within ACK_TIMEOUT cycles, the word counts as sent and
// is not retried. busy feeds only registered logic, so it has no
// combinational path to send.
module golden_nonce_queue #(
  parameter int LOOP_LOG2   = 2,
  parameter int DEPTH_LOG2  = 3,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hit0,
  input  logic [31:0]         nonce0,
  input  logic                hit1,
  input  logic [31:0]         nonce1,
  input  logic                busy,
  output logic                send,
  output logic [31:0]         word,
  output logic [DEPTH_LOG2:0] count,
  output logic [15:0]         drop_count,
  output logic [1:0]          dbg_state
);

  import miner_pkg::*;

  localparam logic [31:0] OFFSET   = GOLDEN_NONCE_OFFSET(LOOP_LOG2);
  localparam logic [15:0] ACK_LAST = 16'(ACK_TIMEOUT - 1);

  send_state_t         state;
  logic [15:0]         ack_cnt;
  logic [31:0]         head;
  logic [DEPTH_LOG2:0] fifo_count;
  logic                acc0;
  logic                acc1;
  logic                issue;
  logic [1:0]          drops;

  // The subtraction wraps mod 2^32, so a nonce just past zero maps to the
  // top of the range.
  nonce_fifo_2w1r #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .wr0_en     (hit0),
    .wr0_data   (nonce0 - OFFSET),
    .wr1_en     (hit1),
    .wr1_data   (nonce1 - OFFSET),
    .rd_en      (issue),
    .rd_data    (head),
    .count      (fifo_count),
    .wr0_accept (acc0),
    .wr1_accept (acc1)
  );

  assign count     = fifo_count;
  assign dbg_state = state;

  // Pop the head in the same cycle that it is latched into word.
  assign issue = (state == IDLE) && (fifo_count != '0) && !busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      send    <= 1'b0;
      word    <= '0;
      ack_cnt <= '0;
    end else begin
      send <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            send    <= 1'b1;
            word    <= head;
            ack_cnt <= '0;
            state   <= ACK;
          end
        end
        ACK: begin
          if (busy) begin
            state <= DRAIN;
          end else if (ack_cnt == ACK_LAST) begin
            state <= IDLE;
          end else begin
            ack_cnt <= ack_cnt + 16'd1;
          end
        end
        DRAIN: begin
          if (!busy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign drops = {1'b0, hit0 & ~acc0} + {1'b0, hit1 & ~acc1};

  // Up to two drops can arrive per cycle. Clamp the count so it stops at
  // 0xFFFF and does not wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_count > (16'hFFFF - 16'(drops))) begin
      drop_count <= 16'hFFFF;
    end else begin
      drop_count <= drop_count + 16'(drops);
    end
  end

endmodule

// File: tb/tb_golden_nonce_queue.sv
module tb_golden_nonce_queue;

  logic        clk;
  logic        reset;
  logic        hit0;
  logic [31:0] nonce0;
  logic        hit1;
  logic [31:0] nonce1;
  logic        busy;
  logic        send;
  logic [31:0] word;
  logic [3:0]  count;
  logic [15:0] drop_count;
  logic [1:0]  dbg_state;

  golden_nonce_queue #(
    .LOOP_LOG2   (2),
    .DEPTH_LOG2  (3),
    .ACK_TIMEOUT (15)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .hit0       (hit0),
    .nonce0     (nonce0),
    .hit1       (hit1),
    .nonce1     (nonce1),
    .busy       (busy),
    .send       (send),
    .word       (word),
    .count      (count),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          last_send_cyc = 0;
  int          last_gap = 0;
  logic        prev_send = 1'b0;
  // busy model: mode 0 = transmitter model, mode 1 = forced to busy_force
  int          busy_mode = 0;
  logic        busy_force = 1'b0;
  int          busy_cnt = 0;

  typedef struct {
    logic        h0;
    logic [31:0] n0;
    logic        h1;
    logic [31:0] n1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [3:0]  exp_cnt;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock: sample outputs and update the busy model at negedge, then
  // return just after the next posedge for input driving.
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    cyc++;
    if (!reset && send) begin
      n_cmp++;
      if (prev_send) begin
        n_err++;
        $display("FAIL send_width: send high on consecutive cycles at cyc %0d", cyc);
      end
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_send: got word 0x%08h with nothing expected", word);
      end else begin
        e = exp_q.pop_front();
        check("send_word", word, e);
      end
      last_gap = cyc - last_send_cyc;
      last_send_cyc = cyc;
    end
    prev_send = send && !reset;
    if (reset) busy_cnt = 0;
    if (busy_mode == 0) begin
      if (busy_cnt != 0) begin
        busy = 1'b1;
        busy_cnt--;
      end else begin
        busy = 1'b0;
      end
      if (send && !reset) busy_cnt = 10;
    end else begin
      busy = busy_force;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_hit(input logic h0, input logic [31:0] n0, input logic h1, input logic [31:0] n1);
    hit0 = h0; nonce0 = n0; hit1 = h1; nonce1 = n1;
    tick();
    hit0 = 1'b0; hit1 = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int k = 0;
    while (!(exp_q.size() == 0 && dbg_state == 2'd0 && count == 4'd0 && busy == 1'b0) && k < 400) begin
      tick();
      k++;
    end
    n_cmp++;
    if (k >= 400) begin
      n_err++;
      $display("FAIL %s_drain_timeout: got %0d pending, state %0d, count %0d; expected drained", name, exp_q.size(), dbg_state, count);
      exp_q.delete();
    end
  endtask

  // ---------------- test ----------------
  initial begin
    logic [31:0] n;
    int k;

    vecs[0] = '{1'b1, 32'h0000_1000, 1'b0, 32'h0,         32'h0000_0FDF, 32'h0,         4'd1};
    vecs[1] = '{1'b1, 32'h0000_0100, 1'b1, 32'h8000_0100, 32'h0000_00DF, 32'h8000_00DF, 4'd2};
    vecs[2] = '{1'b1, 32'h0000_0005, 1'b0, 32'h0,         32'hFFFF_FFE4, 32'h0,         4'd1};
    vecs[3] = '{1'b1, 32'h0000_0021, 1'b0, 32'h0,         32'h0000_0000, 32'h0,         4'd1};
    vecs[4] = '{1'b0, 32'h0,         1'b1, 32'h0000_0040, 32'h0,         32'h0000_001F, 4'd1};
    vecs[5] = '{1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,         32'hFFFF_FFDE, 32'h0,         4'd1};
    vecs[6] = '{1'b1, 32'h0000_0000, 1'b1, 32'h0000_0022, 32'hFFFF_FFDF, 32'h0000_0001, 4'd2};

    reset = 1'b1; hit0 = 1'b0; hit1 = 1'b0; nonce0 = '0; nonce1 = '0; busy = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_send",  32'(send), 32'd0);
    check("rst_word",  word, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_drop",  32'(drop_count), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);

    // Table-driven single and dual hits with the transmitter model.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].h0) exp_q.push_back(vecs[i].e0);
      if (vecs[i].h1) exp_q.push_back(vecs[i].e1);
      do_hit(vecs[i].h0, vecs[i].n0, vecs[i].h1, vecs[i].n1);
      check("vec_count_n1", 32'(count), 32'(vecs[i].exp_cnt));
      tick();
      check("vec_send_latency", 32'(send), 32'd1);
      wait_drain("vec");
      check("vec_drop", 32'(drop_count), 32'd0);
      check("vec_word_hold", word, vecs[i].h1 ? vecs[i].e1 : vecs[i].e0);
    end

    // Overflow: busy held high, 5 dual hits into 8 slots. The 5th pair is lost.
    busy_mode = 1; busy_force = 1'b1;
    tick();
    for (int i = 1; i <= 5; i++) begin
      n = 32'h0001_0021 + (i << 8);
      if (i < 5) begin
        exp_q.push_back(n - 32'd33);
        exp_q.push_back(n + 32'h0001_0000 - 32'd33);
      end
      do_hit(1'b1, n, 1'b1, n + 32'h0001_0000);
    end
    check("ovf_count", 32'(count), 32'd8);
    check("ovf_drop",  32'(drop_count), 32'd2);
    busy_mode = 0;
    wait_drain("ovf");
    check("ovf_drop_after", 32'(drop_count), 32'd2);

    // One free slot with two hits: lane 0 is kept and lane 1 is dropped.
    busy_mode = 1; busy_force = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(32'h0002_0000 + i);
      exp_q.push_back(32'h0003_0000 + i);
      do_hit(1'b1, 32'h0002_0021 + i, 1'b1, 32'h0003_0021 + i);
    end
    exp_q.push_back(32'h0004_0000);
    do_hit(1'b1, 32'h0004_0021, 1'b0, 32'h0);
    check("one_free_count7", 32'(count), 32'd7);
    exp_q.push_back(32'h0005_0000);
    do_hit(1'b1, 32'h0005_0021, 1'b1, 32'h0006_0021);
    check("one_free_count8", 32'(count), 32'd8);
    check("one_free_drop",   32'(drop_count), 32'd3);
    busy_mode = 0;
    wait_drain("one_free");

    // Pointer wrap: 20 entries in batches of 4, with pops overlapping writes.
    for (int b = 0; b < 5; b++) begin
      n = 32'h0A00_0000 + (b << 4);
      exp_q.push_back(n - 32'd33);
      exp_q.push_back(n + 32'd1 - 32'd33);
      exp_q.push_back(n + 32'd2 - 32'd33);
      exp_q.push_back(n + 32'd3 - 32'd33);
      do_hit(1'b1, n, 1'b1, n + 32'd1);
      do_hit(1'b1, n + 32'd2, 1'b0, 32'h0);
      do_hit(1'b0, 32'h0, 1'b1, n + 32'd3);
      wait_drain("wrap");
    end
    check("wrap_drop", 32'(drop_count), 32'd3);

    // ACK timeout: busy stuck low. Each word is sent once, 16 cycles apart.
    busy_mode = 1; busy_force = 1'b0;
    exp_q.push_back(32'h0000_3000);
    exp_q.push_back(32'h0000_3001);
    do_hit(1'b1, 32'h0000_3021, 1'b1, 32'h0000_3022);
    wait_drain("ack_to");
    check("ack_to_gap", 32'(last_gap), 32'd16);
    repeat (20) tick();
    check("ack_to_count", 32'(count), 32'd0);
    check("ack_to_word_hold", word, 32'h0000_3001);

    // Reset mid-transfer while in DRAIN with 3 entries queued.
    busy_mode = 0;
    tick();
    exp_q.push_back(32'h0000_4000);
    exp_q.push_back(32'h0000_4001);
    exp_q.push_back(32'h0000_4002);
    exp_q.push_back(32'h0000_4003);
    do_hit(1'b1, 32'h0000_4021, 1'b1, 32'h0000_4022);
    do_hit(1'b1, 32'h0000_4023, 1'b1, 32'h0000_4024);
    k = 0;
    while (dbg_state != 2'd2 && k < 50) begin
      tick();
      k++;
    end
    check("mid_state_drain", 32'(dbg_state), 32'd2);
    check("mid_count3", 32'(count), 32'd3);
    reset = 1'b1;
    #1;
    check("mid_rst_send",  32'(send), 32'd0);
    check("mid_rst_word",  word, 32'd0);
    check("mid_rst_count", 32'(count), 32'd0);
    check("mid_rst_drop",  32'(drop_count), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    reset = 1'b0;
    repeat (30) tick();
    check("post_rst_count", 32'(count), 32'd0);
    exp_q.push_back(32'h0000_5000);
    do_hit(1'b1, 32'h0000_5021, 1'b0, 32'h0);
    wait_drain("post_rst");
    check("post_rst_word", word, 32'h0000_5000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
